// File: rtl/demod_frame_sync.sv
// rtl/demod_frame_sync.sv - symbol unpacker, 16-bit sync hunter and length-framed byte reassembler.
// Optional trailing XOR checksum byte is enabled by defining FRAME_CHECKSUM_EN.
module demod_frame_sync #(
  parameter logic [15:0] SYNC_WORD = 16'hF0B5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sym_valid,
  input  logic [3:0] sym_data,
  input  logic [1:0] mod_sel,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic       sof,
  output logic       eof,
  output logic       frame_ok,
  output logic       frame_err,
  output logic       locked
);

`ifdef FRAME_CHECKSUM_EN
  typedef enum logic [1:0] {HUNT, LEN, PAYLOAD, CHECK} state_t;
`else
  typedef enum logic [1:0] {HUNT, LEN, PAYLOAD} state_t;
`endif

  state_t      state_q, state_d;
  logic [15:0] window_q, window_d;
  logic [6:0]  acc_q, acc_d;
  logic [2:0]  acc_cnt_q, acc_cnt_d;
  logic [1:0]  mod_q, mod_d;
  logic [7:0]  len_q, len_d;
  logic [7:0]  pay_cnt_q, pay_cnt_d;
`ifdef FRAME_CHECKSUM_EN
  logic [7:0]  ck_q, ck_d;
`endif
  logic        bv_d, sof_d, eof_d, ok_d, err_d;
  logic [7:0]  bd_d;

  logic [1:0]  mod_eff;
  logic [2:0]  k;
  logic [3:0]  field, sym_al;
  logic [15:0] win;
  logic        hit;
  logic [1:0]  hit_pos;
  logic [2:0]  rem_n;
  logic [10:0] acc_cat;
  logic [3:0]  cnt_cat;
  logic        done;
  logic [7:0]  byte_val;
  logic [2:0]  left_cnt;
  logic [6:0]  left_acc;
  logic        go_hunt;

  always_comb begin
    // Modulation tracks the live input only while hunting; it is frozen at lock.
    mod_eff = (state_q == HUNT) ? mod_sel : mod_q;
    k       = {1'b0, mod_eff} + 3'd1;
    field   = sym_data & (4'b1111 >> (3'd4 - k));
    sym_al  = field << (3'd4 - k);

    win     = window_q;
    hit     = 1'b0;
    hit_pos = 2'd0;
    for (int p = 0; p < 4; p++) begin
      if (!hit && (3'(p) < k)) begin
        win = {win[14:0], sym_al[2'(3 - p)]};
        if (win == SYNC_WORD) begin
          hit     = 1'b1;
          hit_pos = 2'(p);
        end
      end
    end
    rem_n = k - 3'd1 - {1'b0, hit_pos};

    acc_cat  = ({acc_q, 4'b0000} >> (3'd4 - k)) | {7'b0, field};
    cnt_cat  = {1'b0, acc_cnt_q} + {1'b0, k};
    done     = cnt_cat[3];
    byte_val = 8'(acc_cat >> (cnt_cat - 4'd8));
    left_cnt = cnt_cat[2:0];
    left_acc = acc_cat[6:0] & (7'h7F >> (3'd7 - left_cnt));

    state_d   = state_q;
    window_d  = window_q;
    acc_d     = acc_q;
    acc_cnt_d = acc_cnt_q;
    mod_d     = mod_q;
    len_d     = len_q;
    pay_cnt_d = pay_cnt_q;
`ifdef FRAME_CHECKSUM_EN
    ck_d      = ck_q;
`endif
    bv_d      = 1'b0;
    bd_d      = byte_data;
    sof_d     = 1'b0;
    eof_d     = 1'b0;
    ok_d      = 1'b0;
    err_d     = 1'b0;
    go_hunt   = 1'b0;

    if (sym_valid) begin
      if (state_q != HUNT) begin
        acc_d     = done ? left_acc : acc_cat[6:0];
        acc_cnt_d = done ? left_cnt : cnt_cat[2:0];
      end
      case (state_q)
        HUNT: begin
          if (hit) begin
            state_d   = LEN;
            mod_d     = mod_sel;
            window_d  = '0;
            acc_d     = {3'b000, field & (4'b1111 >> (3'd4 - rem_n))};
            acc_cnt_d = rem_n;
          end else begin
            window_d = win;
          end
        end
        LEN: begin
          if (done) begin
            if (byte_val == 8'h00) begin
              err_d   = 1'b1;
              go_hunt = 1'b1;
            end else begin
              len_d     = byte_val;
              pay_cnt_d = byte_val;
              state_d   = PAYLOAD;
`ifdef FRAME_CHECKSUM_EN
              ck_d      = byte_val;
`endif
            end
          end
        end
        PAYLOAD: begin
          if (done) begin
            bv_d      = 1'b1;
            bd_d      = byte_val;
            sof_d     = (pay_cnt_q == len_q);
            eof_d     = (pay_cnt_q == 8'd1);
            pay_cnt_d = pay_cnt_q - 8'd1;
`ifdef FRAME_CHECKSUM_EN
            ck_d      = ck_q ^ byte_val;
            if (pay_cnt_q == 8'd1) state_d = CHECK;
`else
            if (pay_cnt_q == 8'd1) begin
              ok_d    = 1'b1;
              go_hunt = 1'b1;
            end
`endif
          end
        end
`ifdef FRAME_CHECKSUM_EN
        CHECK: begin
          if (done) begin
            ok_d    = (byte_val == ck_q);
            err_d   = (byte_val != ck_q);
            go_hunt = 1'b1;
          end
        end
`endif
        default: go_hunt = 1'b1;
      endcase
    end

    // Leaving a frame drops any partial bits, including the rest of this symbol.
    if (go_hunt) begin
      state_d   = HUNT;
      acc_d     = '0;
      acc_cnt_d = '0;
      window_d  = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= HUNT;
      window_q   <= '0;
      acc_q      <= '0;
      acc_cnt_q  <= '0;
      mod_q      <= '0;
      len_q      <= '0;
      pay_cnt_q  <= '0;
`ifdef FRAME_CHECKSUM_EN
      ck_q       <= '0;
`endif
      byte_valid <= 1'b0;
      byte_data  <= 8'h00;
      sof        <= 1'b0;
      eof        <= 1'b0;
      frame_ok   <= 1'b0;
      frame_err  <= 1'b0;
      locked     <= 1'b0;
    end else begin
      state_q    <= state_d;
      window_q   <= window_d;
      acc_q      <= acc_d;
      acc_cnt_q  <= acc_cnt_d;
      mod_q      <= mod_d;
      len_q      <= len_d;
      pay_cnt_q  <= pay_cnt_d;
`ifdef FRAME_CHECKSUM_EN
      ck_q       <= ck_d;
`endif
      byte_valid <= bv_d;
      byte_data  <= bd_d;
      sof        <= sof_d;
      eof        <= eof_d;
      frame_ok   <= ok_d;
      frame_err  <= err_d;
      locked     <= (state_d != HUNT);
    end
  end

endmodule

// File: tb/tb_demod_frame_sync.sv
// tb/tb_demod_frame_sync.sv - table-driven directed bench for demod_frame_sync (both FRAME_CHECKSUM_EN builds).
module tb_demod_frame_sync;

  logic       clk = 1'b0;
  logic       rst;
  logic       sym_valid;
  logic [3:0] sym_data;
  logic [1:0] mod_sel;
  logic       byte_valid;
  logic [7:0] byte_data;
  logic       sof, eof, frame_ok, frame_err, locked;

`ifdef FRAME_CHECKSUM_EN
  localparam logic CK = 1'b1;
`else
  localparam logic CK = 1'b0;
`endif

  demod_frame_sync dut (
    .clk(clk), .rst(rst), .sym_valid(sym_valid), .sym_data(sym_data), .mod_sel(mod_sel),
    .byte_valid(byte_valid), .byte_data(byte_data), .sof(sof), .eof(eof),
    .frame_ok(frame_ok), .frame_err(frame_err), .locked(locked)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       vld;
    logic [1:0] mod;
    logic [3:0] sym;
    logic       bv;
    logic [7:0] bd;
    logic       sof;
    logic       eof;
    logic       ok;
    logic       err;
    logic       lock;
  } vec_t;

  vec_t vecs[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   vec_id   = 0;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  task automatic push(input logic vld, input logic [1:0] m, input logic [3:0] s, input logic bv,
                      input logic [7:0] bd, input logic so, input logic eo, input logic ok,
                      input logic er, input logic lk);
    vec_t v;
    v.vld = vld; v.mod = m; v.sym = s; v.bv = bv; v.bd = bd;
    v.sof = so; v.eof = eo; v.ok = ok; v.err = er; v.lock = lk;
    vecs.push_back(v);
  endtask

  task automatic sym(input logic [1:0] m, input logic [3:0] s, input logic lk);
    push(1'b1, m, s, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, lk);
  endtask

  task automatic qpsk_sync();
    logic [3:0] s [8] = '{4'd3, 4'd3, 4'd0, 4'd0, 4'd2, 4'd3, 4'd1, 4'd1};
    for (int i = 0; i < 8; i++) sym(2'd1, s[i], i == 7);
  endtask

  // Frame L=2, A5 3C; after lock mod_sel is driven to BPSK, which must be ignored.
  task automatic qpsk_frame(input logic bad_ck);
    qpsk_sync();
    sym(2'd1, 4'd0, 1'b1); sym(2'd1, 4'd0, 1'b1); sym(2'd1, 4'd0, 1'b1); sym(2'd1, 4'd2, 1'b1);
    sym(2'd0, 4'd2, 1'b1); sym(2'd0, 4'd2, 1'b1); sym(2'd0, 4'd1, 1'b1);
    push(1'b1, 2'd0, 4'd1, 1'b1, 8'hA5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    push(1'b0, 2'd0, 4'hF, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    sym(2'd0, 4'd0, 1'b1); sym(2'd0, 4'd3, 1'b1); sym(2'd0, 4'd3, 1'b1);
    push(1'b1, 2'd0, 4'd0, 1'b1, 8'h3C, 1'b0, 1'b1, !CK, 1'b0, CK);
`ifdef FRAME_CHECKSUM_EN
    sym(2'd1, 4'd2, 1'b1); sym(2'd1, 4'd1, 1'b1); sym(2'd1, 4'd2, 1'b1);
    push(1'b1, 2'd1, bad_ck ? 4'd2 : 4'd3, 1'b0, 8'h00, 1'b0, 1'b0, !bad_ck, bad_ck, 1'b0);
`else
    if (bad_ck) sym(2'd1, 4'd0, 1'b0);
`endif
  endtask

  task automatic run_all();
    foreach (vecs[i]) begin
      @(negedge clk);
      sym_valid = vecs[i].vld;
      sym_data  = vecs[i].sym;
      mod_sel   = vecs[i].mod;
      @(posedge clk);
      #1;
      chk($sformatf("v%0d byte_valid", vec_id), {7'b0, byte_valid}, {7'b0, vecs[i].bv});
      if (vecs[i].bv) chk($sformatf("v%0d byte_data", vec_id), byte_data, vecs[i].bd);
      chk($sformatf("v%0d sof", vec_id), {7'b0, sof}, {7'b0, vecs[i].sof});
      chk($sformatf("v%0d eof", vec_id), {7'b0, eof}, {7'b0, vecs[i].eof});
      chk($sformatf("v%0d frame_ok", vec_id), {7'b0, frame_ok}, {7'b0, vecs[i].ok});
      chk($sformatf("v%0d frame_err", vec_id), {7'b0, frame_err}, {7'b0, vecs[i].err});
      chk($sformatf("v%0d locked", vec_id), {7'b0, locked}, {7'b0, vecs[i].lock});
      vec_id++;
    end
    @(negedge clk);
    sym_valid = 1'b0;
    vecs.delete();
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, " byte_valid"}, {7'b0, byte_valid}, 8'h00);
    chk({tag, " byte_data"}, byte_data, 8'h00);
    chk({tag, " sof"}, {7'b0, sof}, 8'h00);
    chk({tag, " eof"}, {7'b0, eof}, 8'h00);
    chk({tag, " frame_ok"}, {7'b0, frame_ok}, 8'h00);
    chk({tag, " frame_err"}, {7'b0, frame_err}, 8'h00);
    chk({tag, " locked"}, {7'b0, locked}, 8'h00);
  endtask

  initial begin
    logic [15:0] sw;
    logic [7:0]  b;
    logic [3:0]  s8 [11];
    rst = 1'b1; sym_valid = 1'b0; sym_data = 4'h0; mod_sel = 2'd0;
    @(posedge clk); #1;
    chk_zero("reset");
    @(negedge clk);
    rst = 1'b0;

    // QPSK frame from the basic example.
    qpsk_frame(1'b0);

    // BPSK: junk 101, sync bitwise, L=01, payload 5A; upper symbol bits are noise.
    sym(2'd0, 4'b1101, 1'b0); sym(2'd0, 4'b1100, 1'b0); sym(2'd0, 4'b1011, 1'b0);
    sw = 16'hF0B5;
    for (int i = 15; i >= 0; i--) sym(2'd0, {3'b101, sw[i]}, i == 0);
    b = 8'h01;
    for (int i = 7; i >= 0; i--) sym(2'd0, {3'b011, b[i]}, 1'b1);
    b = 8'h5A;
    for (int i = 7; i >= 1; i--) sym(2'd0, {3'b000, b[i]}, 1'b1);
    push(1'b1, 2'd0, 4'd0, 1'b1, 8'h5A, 1'b1, 1'b1, !CK, 1'b0, CK);
`ifdef FRAME_CHECKSUM_EN
    b = 8'h5B;
    for (int i = 7; i >= 1; i--) sym(2'd0, {3'b000, b[i]}, 1'b1);
    push(1'b1, 2'd0, {3'b000, b[0]}, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
`endif

    // 8PSK: sync ends on first bit of a symbol, two leftover bits start L; bit 3 is noise.
    s8 = '{4'd7, 4'd4, 4'd1, 4'd3, 4'd2, 4'd4, 4'd0, 4'd1, 4'd6, 4'd0, 4'd7};
    for (int i = 0; i < 10; i++) sym(2'd2, s8[i] | 4'h8, i >= 5);
    push(1'b1, 2'd2, 4'hF, 1'b1, 8'hC3, 1'b1, 1'b1, !CK, 1'b0, CK);
`ifdef FRAME_CHECKSUM_EN
    sym(2'd2, 4'hC, 1'b1); sym(2'd2, 4'h9, 1'b1);
    push(1'b1, 2'd2, 4'h8, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
`endif

    // 16QAM: sync F,0,B,5, L=01, payload E7 (checksum E6).
    sym(2'd3, 4'hF, 1'b0); sym(2'd3, 4'h0, 1'b0); sym(2'd3, 4'hB, 1'b0); sym(2'd3, 4'h5, 1'b1);
    sym(2'd3, 4'h0, 1'b1); sym(2'd3, 4'h1, 1'b1); sym(2'd3, 4'hE, 1'b1);
    push(1'b1, 2'd3, 4'h7, 1'b1, 8'hE7, 1'b1, 1'b1, !CK, 1'b0, CK);
`ifdef FRAME_CHECKSUM_EN
    sym(2'd3, 4'hE, 1'b1);
    push(1'b1, 2'd3, 4'h6, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
`endif

    // L=0 rejected, then a normal frame; checksum builds also see a bad checksum.
    qpsk_sync();
    sym(2'd1, 4'd0, 1'b1); sym(2'd1, 4'd0, 1'b1); sym(2'd1, 4'd0, 1'b1);
    push(1'b1, 2'd1, 4'd0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    qpsk_frame(1'b0);
`ifdef FRAME_CHECKSUM_EN
    qpsk_frame(1'b1);
`endif
    run_all();

    // Reset after the first of two payload bytes.
    qpsk_sync();
    sym(2'd1, 4'd0, 1'b1); sym(2'd1, 4'd0, 1'b1); sym(2'd1, 4'd0, 1'b1); sym(2'd1, 4'd2, 1'b1);
    sym(2'd1, 4'd2, 1'b1); sym(2'd1, 4'd2, 1'b1); sym(2'd1, 4'd1, 1'b1);
    push(1'b1, 2'd1, 4'd1, 1'b1, 8'hA5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    run_all();
    rst = 1'b1;
    #1;
    chk_zero("midframe_rst");
    @(negedge clk);
    rst = 1'b0;
    sym(2'd1, 4'd0, 1'b0); sym(2'd1, 4'd3, 1'b0); sym(2'd1, 4'd3, 1'b0); sym(2'd1, 4'd0, 1'b0);
    qpsk_frame(1'b0);
    run_all();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
